// File: rtl/sram_mux_pkg.sv
// sram_mux_pkg: shared slot, lane and latency definitions for the SRAM multiport scheduler
package sram_mux_pkg;
  localparam int LATENCY = 2;
  typedef logic [2:0] slot_t;
  typedef enum logic {LANE_LO, LANE_HI} lane_e;
endpackage

// File: rtl/sram_lane_select.sv
// sram_lane_select: steers the write byte onto a DQ lane and extracts the read byte from it
module sram_lane_select
  import sram_mux_pkg::*;
(
  input  lane_e       i_lane,
  input  logic [7:0]  i_wdata,
  input  logic [15:0] i_dq,
  output logic [15:0] o_dq,
  output logic [7:0]  o_rbyte
);
  assign o_dq    = i_lane == LANE_HI ? {i_wdata, 8'h00} : {8'h00, i_wdata};
  assign o_rbyte = i_lane == LANE_HI ? i_dq[15:8] : i_dq[7:0];
endmodule

// File: rtl/sram_multiport_scheduler.sv
// sram_multiport_scheduler: TDM arbiter sharing one async SRAM between Avalon-MM and NUM_HW read ports.
// Define SRAM_MUX_SLOT_SKIP_EN to skip slots whose owner is not requesting.
module sram_multiport_scheduler
  import sram_mux_pkg::*;
#(
  parameter int NUM_HW = 2,
  parameter int ADDR_W = 21
) (
  input  logic                     CLK2,
  input  logic                     RESET,
  input  logic                     AVL_READ,
  input  logic                     AVL_WRITE,
  input  logic [ADDR_W-1:0]        AVL_ADDR,
  input  logic [7:0]               AVL_WRITEDATA,
  output logic                     AVL_WAITREQUEST,
  output logic [7:0]               AVL_READDATA,
  output logic                     AVL_READDATAVALID,
  input  logic [NUM_HW-1:0]        HW_REQ,
  input  logic [NUM_HW*ADDR_W-1:0] HW_ADDR,
  output logic [NUM_HW-1:0]        HW_ACK,
  output logic [NUM_HW-1:0]        HW_RVALID,
  output logic [NUM_HW*8-1:0]      HW_READDATA,
  output logic [ADDR_W-2:0]        SRAM_ADDR,
  inout  wire  [15:0]              SRAM_DQ,
  output logic                     SRAM_CE_N,
  output logic                     SRAM_OE_N,
  output logic                     SRAM_WE_N,
  output logic                     SRAM_LB_N,
  output logic                     SRAM_UB_N
);
  slot_t               r_slot, r_rd_owner, w_next;
  logic [ADDR_W-2:0]   r_addr;
  logic                r_oe_n, r_we_n, r_lb_n, r_ub_n, r_rd_valid, r_avl_rvalid;
  lane_e               r_lane;
  logic [7:0]          r_wdata, r_avl_rdata, w_rbyte;
  logic [NUM_HW-1:0]   r_hw_rvalid;
  logic [NUM_HW*8-1:0] r_hw_rdata;
  logic [15:0]         w_dq_out;
  logic [ADDR_W-1:0]   w_addr;
  logic [7:0]          w_req;
  logic                w_avl_req, w_grant, w_wr;
  assign w_avl_req = AVL_READ | AVL_WRITE;
  assign w_req     = 8'({HW_REQ, w_avl_req});
  assign w_grant   = w_req[r_slot];
  assign w_wr      = r_slot == '0 && AVL_WRITE;
  always_comb begin
    w_addr = AVL_ADDR;
    for (int i = 0; i < NUM_HW; i++)
      if (r_slot == slot_t'(i + 1)) w_addr = HW_ADDR[i*ADDR_W +: ADDR_W];
  end
  always_comb begin
    HW_ACK = '0;
    for (int i = 0; i < NUM_HW; i++)
      HW_ACK[i] = !RESET && HW_REQ[i] && r_slot == slot_t'(i + 1);
  end
  assign AVL_WAITREQUEST = !(!RESET && r_slot == '0 && w_avl_req);
`ifdef SRAM_MUX_SLOT_SKIP_EN
  // Lowest cyclic distance wins; distance NUM_HW+1 is the current owner itself.
  always_comb begin
    w_next = '0;
    for (int k = NUM_HW + 1; k >= 1; k--)
      if (w_req[slot_t'((int'(r_slot) + k) % (NUM_HW + 1))])
        w_next = slot_t'((int'(r_slot) + k) % (NUM_HW + 1));
  end
`else
  assign w_next = r_slot == slot_t'(NUM_HW) ? '0 : slot_t'(r_slot + 1'b1);
`endif
  sram_lane_select u_lane (
    .i_lane  (r_lane),
    .i_wdata (r_wdata),
    .i_dq    (SRAM_DQ),
    .o_dq    (w_dq_out),
    .o_rbyte (w_rbyte)
  );
  assign SRAM_DQ           = r_we_n ? 16'hzzzz : w_dq_out;
  assign SRAM_ADDR         = r_addr;
  assign SRAM_CE_N         = 1'b0;
  assign SRAM_OE_N         = r_oe_n;
  assign SRAM_WE_N         = r_we_n;
  assign SRAM_LB_N         = r_lb_n;
  assign SRAM_UB_N         = r_ub_n;
  assign AVL_READDATA      = r_avl_rdata;
  assign AVL_READDATAVALID = r_avl_rvalid;
  assign HW_READDATA       = r_hw_rdata;
  assign HW_RVALID         = r_hw_rvalid;
  always_ff @(posedge CLK2) begin
    if (RESET) begin
      r_slot       <= '0;
      r_addr       <= '0;
      r_oe_n       <= 1'b1;
      r_we_n       <= 1'b1;
      r_lb_n       <= 1'b1;
      r_ub_n       <= 1'b1;
      r_lane       <= LANE_LO;
      r_wdata      <= '0;
      r_rd_valid   <= 1'b0;
      r_rd_owner   <= '0;
      r_avl_rvalid <= 1'b0;
      r_avl_rdata  <= '0;
      r_hw_rvalid  <= '0;
      r_hw_rdata   <= '0;
    end else begin
      r_slot     <= w_next;
      r_oe_n     <= !(w_grant && !w_wr);
      r_we_n     <= !(w_grant && w_wr);
      r_lb_n     <= !(w_grant && !w_addr[0]);
      r_ub_n     <= !(w_grant && w_addr[0]);
      r_rd_valid <= w_grant && !w_wr;
      if (w_grant) begin
        r_addr     <= w_addr[ADDR_W-1:1];
        r_lane     <= lane_e'(w_addr[0]);
        r_wdata    <= AVL_WRITEDATA;
        r_rd_owner <= r_slot;
      end
      // Second stage: the SRAM has had the whole pin cycle to settle.
      r_avl_rvalid <= r_rd_valid && r_rd_owner == '0;
      if (r_rd_valid && r_rd_owner == '0) r_avl_rdata <= w_rbyte;
      for (int i = 0; i < NUM_HW; i++) begin
        r_hw_rvalid[i] <= r_rd_valid && r_rd_owner == slot_t'(i + 1);
        if (r_rd_valid && r_rd_owner == slot_t'(i + 1)) r_hw_rdata[i*8 +: 8] <= w_rbyte;
      end
    end
  end
endmodule
